// File: rtl/led_band_synchronizer.sv
// rtl/led_band_synchronizer.sv - LED band driver sequencer: GS frame shifting and FC register writes
module led_band_synchronizer #(
    parameter int NB_LED_ROWS       = 32,
    parameter int NB_ANGLES         = 128,
    parameter int COLOR_DATA_WIDTH  = 8,
    parameter int NB_ADDED_LSB_BITS = 1,
    parameter int SCLK_HALF         = 2,
    localparam int W             = COLOR_DATA_WIDTH + NB_ADDED_LSB_BITS,
    localparam int ANGLE_WIDTH   = $clog2(NB_ANGLES),
    localparam int LED_ROW_WIDTH = $clog2(NB_LED_ROWS),
    localparam int BIT_SEL_WIDTH = $clog2(W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     angle_valid,
    input  logic [ANGLE_WIDTH-1:0]   angle_in,
    input  logic                     fc_req,
    output logic                     SCLK,
    output logic                     LAT,
    output logic [ANGLE_WIDTH-1:0]   angle,
    output logic [LED_ROW_WIDTH-1:0] led_row,
    output logic [1:0]               color,
    output logic [BIT_SEL_WIDTH-1:0] bit_sel,
    output logic                     busy,
    output logic                     overrun
);

    // Phase counter runs 0..2*SCLK_HALF-1 inside every SCLK period.
    localparam int PH_W = $clog2(2 * SCLK_HALF);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * SCLK_HALF - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(SCLK_HALF);

    localparam logic [LED_ROW_WIDTH-1:0] LAST_ROW = LED_ROW_WIDTH'(NB_LED_ROWS - 1);
    localparam logic [BIT_SEL_WIDTH-1:0] BIT_TOP  = BIT_SEL_WIDTH'(W - 1);

    // FC command sequence lengths, counted in SCLK periods.
    localparam logic [5:0] FC_EN_LAST    = 6'd14;
    localparam logic [5:0] FC_SHIFT_LAST = 6'd47;
    localparam logic [5:0] WRTFC_FIRST   = 6'd43;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GS       = 2'd1,
        S_FC_EN    = 2'd2,
        S_FC_SHIFT = 2'd3
    } state_t;

    state_t                   r_state;
    logic [PH_W-1:0]          r_phase;
    logic [5:0]               r_fc_cnt;
    logic                     r_angle_pend;
    logic [ANGLE_WIDTH-1:0]   r_angle_pend_val;
    logic                     r_fc_pend;

    logic                     r_sclk;
    logic                     r_lat;
    logic [ANGLE_WIDTH-1:0]   r_angle;
    logic [LED_ROW_WIDTH-1:0] r_row;
    logic [1:0]               r_color;
    logic [BIT_SEL_WIDTH-1:0] r_bit;
    logic                     r_busy;
    logic                     r_overrun;

    // A request pulse seen while idle is acted on in the same edge as a stored flag.
    logic w_fc_any;
    logic w_angle_any;
    assign w_fc_any    = r_fc_pend | fc_req;
    assign w_angle_any = r_angle_pend | angle_valid;

    // LAT level for a GS period: WRTGS on the last bit of inner rows, LATGS on the
    // final three periods of the last row.
    function automatic logic lat_gs(
        input logic [LED_ROW_WIDTH-1:0] row,
        input logic [1:0]               col,
        input logic [BIT_SEL_WIDTH-1:0] bsel
    );
        int remaining;
        remaining = int'(col) * W + int'(bsel);
        if (row == LAST_ROW) begin
            lat_gs = (remaining <= 2);
        end else begin
            lat_gs = (remaining == 0);
        end
    endfunction

    // Sequencer: request capture, state transitions, phase/index counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_phase          <= '0;
            r_fc_cnt         <= '0;
            r_angle_pend     <= 1'b0;
            r_angle_pend_val <= '0;
            r_fc_pend        <= 1'b0;
            r_sclk           <= 1'b0;
            r_lat            <= 1'b0;
            r_angle          <= '0;
            r_row            <= '0;
            r_color          <= '0;
            r_bit            <= '0;
            r_busy           <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            // Requests are always captured; a consuming transition below clears the flag.
            r_overrun <= angle_valid & r_angle_pend;
            if (angle_valid) begin
                r_angle_pend     <= 1'b1;
                r_angle_pend_val <= angle_in;
            end
            if (fc_req) begin
                r_fc_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_phase  <= '0;
                    r_fc_cnt <= '0;
                    r_sclk   <= 1'b0;
                    r_lat    <= 1'b0;
                    r_row    <= '0;
                    r_color  <= '0;
                    r_bit    <= '0;
                    r_busy   <= 1'b0;
                    if (w_fc_any) begin
                        // FC writes go ahead of a waiting frame.
                        r_fc_pend <= 1'b0;
                        r_state   <= S_FC_EN;
                        r_busy    <= 1'b1;
                        r_lat     <= 1'b1;
                    end else if (w_angle_any) begin
                        // The newest angle wins when a pulse coincides with a stored one.
                        r_angle_pend <= 1'b0;
                        r_angle      <= angle_valid ? angle_in : r_angle_pend_val;
                        r_state      <= S_GS;
                        r_busy       <= 1'b1;
                        r_color      <= 2'd2;
                        r_bit        <= BIT_TOP;
                        r_lat        <= lat_gs('0, 2'd2, BIT_TOP);
                    end
                end

                S_GS: begin
                    if (r_phase == PH_LAST) begin
                        r_phase <= '0;
                        r_sclk  <= 1'b0;
                        if (r_bit != '0) begin
                            r_bit <= r_bit - 1'b1;
                            r_lat <= lat_gs(r_row, r_color, r_bit - 1'b1);
                        end else if (r_color != '0) begin
                            r_bit   <= BIT_TOP;
                            r_color <= r_color - 1'b1;
                            r_lat   <= lat_gs(r_row, r_color - 1'b1, BIT_TOP);
                        end else if (r_row != LAST_ROW) begin
                            r_bit   <= BIT_TOP;
                            r_color <= 2'd2;
                            r_row   <= r_row + 1'b1;
                            r_lat   <= lat_gs(r_row + 1'b1, 2'd2, BIT_TOP);
                        end else begin
                            // Frame complete; angle is kept, indices go back to zero.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_lat   <= 1'b0;
                            r_row   <= '0;
                            r_color <= '0;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                        r_sclk  <= ((r_phase + 1'b1) >= PH_HIGH);
                    end
                end

                S_FC_EN: begin
                    if (r_phase == PH_LAST) begin
                        r_phase <= '0;
                        r_sclk  <= 1'b0;
                        if (r_fc_cnt == FC_EN_LAST) begin
                            r_fc_cnt <= '0;
                            r_state  <= S_FC_SHIFT;
                            r_lat    <= 1'b0;
                        end else begin
                            r_fc_cnt <= r_fc_cnt + 1'b1;
                            r_lat    <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                        r_sclk  <= ((r_phase + 1'b1) >= PH_HIGH);
                    end
                end

                S_FC_SHIFT: begin
                    if (r_phase == PH_LAST) begin
                        r_phase <= '0;
                        r_sclk  <= 1'b0;
                        if (r_fc_cnt == FC_SHIFT_LAST) begin
                            r_fc_cnt <= '0;
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_lat    <= 1'b0;
                        end else begin
                            r_fc_cnt <= r_fc_cnt + 1'b1;
                            r_lat    <= ((r_fc_cnt + 1'b1) >= WRTFC_FIRST);
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                        r_sclk  <= ((r_phase + 1'b1) >= PH_HIGH);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_lat   <= 1'b0;
                    r_sclk  <= 1'b0;
                    r_phase <= '0;
                end
            endcase
        end
    end

    assign SCLK    = r_sclk;
    assign LAT     = r_lat;
    assign angle   = r_angle;
    assign led_row = r_row;
    assign color   = r_color;
    assign bit_sel = r_bit;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule
